// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word stream feeding the UART transmitter FIFO.
// The source drives data/valid; the transmitter answers with ready.
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, none/odd/even parity, 1 or 2 stop bits)
// with a word FIFO so consecutive frames leave the pin with no idle gap.
module uart_tx_cfg #(
   parameter int CLK_FRE    = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   uart_tx_cfg_if.slave                  s_tx,
   output logic                          tx,
   output logic                          busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CNT_MAX = CLK_FRE / BAUD_RATE;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW      = AW + 1;

   if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_MAX < 2) begin : g_bad_params
      $error("uart_tx_cfg: illegal parameter combination");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        count;
   logic                 push, pop, not_empty;
   logic [DATA_BITS-1:0] fifo_head;

   state_t               state, state_next;
   logic [CW-1:0]        baud_cnt;
   logic [3:0]           bit_cnt;
   logic                 bit_end;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 tx_next, done_next;

   assign s_tx.ready = (count != LW'(FIFO_DEPTH));
   assign push       = s_tx.valid && s_tx.ready;
   assign not_empty  = (count != '0);
   assign fifo_head  = mem[rd_ptr];
   assign fifo_level = count;
   assign bit_end    = (baud_cnt == CW'(CNT_MAX - 1));

   // NOTE: storage array has no reset; validity is tracked entirely by count and the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_tx.data;
   end

   // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: outputs of this block get defaults first so no path through the case can infer a latch.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      tx_next    = 1'b1;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (not_empty) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (bit_end) state_next = DATA;
         end
         DATA: begin
            tx_next = shreg[0];
            if (bit_end && bit_cnt == 4'(DATA_BITS - 1))
               state_next = (PARITY != 0) ? PAR : STOP;
         end
         PAR: begin
            tx_next = par_bit;
            if (bit_end) state_next = STOP;
         end
         STOP: begin
            if (bit_end && bit_cnt == 4'(STOP_BITS - 1)) begin
               done_next = 1'b1;
               if (not_empty) begin
                  pop        = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   // tx, tx_done and busy are all registered from the current state, so they share one cycle of lag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx       <= 1'b1;
         tx_done  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + CW'(1);
         if (state_next != state)
            bit_cnt <= '0;
         else if (bit_end && (state == DATA || state == STOP))
            bit_cnt <= bit_cnt + 4'd1;
         if (pop) begin
            shreg   <= fifo_head;
            par_bit <= (PARITY == 1) ? ~(^fifo_head) : ^fifo_head;
         end else if (state == DATA && bit_end) begin
            shreg <= shreg >> 1;
         end
         tx      <= tx_next;
         tx_done <= done_next;
         busy    <= not_empty || (state != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: four transmitter configurations (8N1, 7E2, 7O2, 9N1) checked
// cycle by cycle against frames built from the word, parity and stop-bit rules.
module tb_uart_tx_cfg;

   localparam int CLK_FRE = 1_000_000;
   localparam int BAUD    = 100_000;
   localparam int CNT     = CLK_FRE / BAUD;
   localparam int DEPTH   = 16;
   localparam int LVW     = $clog2(DEPTH) + 1;
   localparam int SEND_LIMIT  = 3000;
   localparam int DRAIN_LIMIT = 20000;

   logic clk = 1'b0;
   logic rstn = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [8:0]     wdata [4];
   logic [3:0]     wvalid;
   logic [3:0]     rdy_v, tx_v, busy_v, done_v;
   logic [LVW-1:0] level [4];

   int dbits [4] = '{8, 7, 7, 9};
   int pmode [4] = '{0, 2, 1, 0};
   int stops [4] = '{1, 2, 2, 1};

   int q0[$], q1[$], q2[$], q3[$];

   uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
   uart_tx_cfg_if #(.DATA_BITS(7)) if1 ();
   uart_tx_cfg_if #(.DATA_BITS(7)) if2 ();
   uart_tx_cfg_if #(.DATA_BITS(9)) if3 ();

   assign if0.data  = wdata[0][7:0];
   assign if1.data  = wdata[1][6:0];
   assign if2.data  = wdata[2][6:0];
   assign if3.data  = wdata[3];
   assign if0.valid = wvalid[0];
   assign if1.valid = wvalid[1];
   assign if2.valid = wvalid[2];
   assign if3.valid = wvalid[3];
   assign rdy_v     = {if3.ready, if2.ready, if1.ready, if0.ready};

   uart_tx_cfg #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
      .clk(clk), .rstn(rstn), .s_tx(if0), .tx(tx_v[0]), .busy(busy_v[0]),
      .tx_done(done_v[0]), .fifo_level(level[0]));

   uart_tx_cfg #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u1 (
      .clk(clk), .rstn(rstn), .s_tx(if1), .tx(tx_v[1]), .busy(busy_v[1]),
      .tx_done(done_v[1]), .fifo_level(level[1]));

   uart_tx_cfg #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u2 (
      .clk(clk), .rstn(rstn), .s_tx(if2), .tx(tx_v[2]), .busy(busy_v[2]),
      .tx_done(done_v[2]), .fifo_level(level[2]));

   uart_tx_cfg #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .DATA_BITS(9), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u3 (
      .clk(clk), .rstn(rstn), .s_tx(if3), .tx(tx_v[3]), .busy(busy_v[3]),
      .tx_done(done_v[3]), .fifo_level(level[3]));

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int mask(input int k);
      return (1 << dbits[k]) - 1;
   endfunction

   function automatic void push_exp(input int k, input int w);
      case (k)
         0: q0.push_back(w);
         1: q1.push_back(w);
         2: q2.push_back(w);
         default: q3.push_back(w);
      endcase
   endfunction

   function automatic bit pop_exp(input int k, output int w);
      w = 0;
      case (k)
         0: if (q0.size() > 0) begin w = q0.pop_front(); return 1'b1; end
         1: if (q1.size() > 0) begin w = q1.pop_front(); return 1'b1; end
         2: if (q2.size() > 0) begin w = q2.pop_front(); return 1'b1; end
         default: if (q3.size() > 0) begin w = q3.pop_front(); return 1'b1; end
      endcase
      return 1'b0;
   endfunction

   function automatic int qsize(input int k);
      case (k)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   // Line level of bit-time idx of the frame carrying word w on instance k.
   function automatic bit frame_bit(input int k, input int w, input int idx);
      int ones;
      ones = $countones(w & mask(k));
      if (idx == 0) return 1'b0;
      if (idx <= dbits[k]) return 1'(w >> (idx - 1));
      if (pmode[k] != 0 && idx == dbits[k] + 1)
         return (pmode[k] == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
      return 1'b1;
   endfunction

   task automatic monitor(input int k);
      int w, len, bad, dbad;
      bit aborted;
      forever begin
         @(negedge clk);
         if (rstn && tx_v[k] == 1'b0) begin
            if (!pop_exp(k, w)) begin
               check($sformatf("u%0d_unexpected_frame", k), 1, 0);
            end else begin
               len = CNT * (1 + dbits[k] + ((pmode[k] != 0) ? 1 : 0) + stops[k]);
               bad = 0;
               dbad = 0;
               aborted = 1'b0;
               for (int c = 0; c < len; c++) begin
                  if (c > 0) @(negedge clk);
                  if (!rstn) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (tx_v[k] !== frame_bit(k, w, c / CNT)) bad++;
                  if (done_v[k] !== (c == len - 1)) dbad++;
               end
               if (!aborted) begin
                  check($sformatf("u%0d_frame_bits_w%0h", k, w), bad, 0);
                  check($sformatf("u%0d_frame_done_w%0h", k, w), dbad, 0);
               end
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);
   initial monitor(2);
   initial monitor(3);

   // Called just after a falling edge; returns just after the falling edge following acceptance.
   task automatic send(input int k, input int w);
      int waited = 0;
      wdata[k]  = 9'(w);
      wvalid[k] = 1'b1;
      while (!rdy_v[k] && waited < SEND_LIMIT) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= SEND_LIMIT) begin
         check($sformatf("u%0d_send_timeout", k), waited, 0);
      end else begin
         push_exp(k, w & mask(k));
         @(negedge clk);
      end
      wvalid[k] = 1'b0;
   endtask

   task automatic drain(input int k);
      int n = 0;
      while ((qsize(k) != 0 || busy_v[k]) && n < DRAIN_LIMIT) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("u%0d_drain", k), (qsize(k) != 0) || busy_v[k], 0);
   endtask

   initial begin
      int n, acc, ndone, prev, cyc, gap_bad, quiet, w;
      bit full_seen;

      wvalid = '0;
      for (int k = 0; k < 4; k++) wdata[k] = '0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_tx", tx_v[0], 1);
      check("rst_ready", rdy_v[0], 1);
      check("rst_busy", busy_v[0], 0);
      check("rst_done", done_v[0], 0);
      check("rst_level", level[0], 0);

      rstn = 1'b1;
      @(negedge clk);

      // 8N1 single word: latency, tx_done placement and busy release
      send(0, 'h55);
      check("lat_tx_after_accept", tx_v[0], 1);
      @(negedge clk);
      check("lat_tx_after_pop", tx_v[0], 1);
      @(negedge clk);
      check("lat_tx_start_bit", tx_v[0], 0);
      n = 1;
      while (!done_v[0] && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("done_frame_cycle", n, 10 * CNT);
      check("busy_at_done", busy_v[0], 1);
      @(negedge clk);
      check("busy_after_done", busy_v[0], 0);

      // 7E2, 7O2 and 9N1 directed words followed by random words
      send(1, 'h41);
      send(2, 'h41);
      send(3, 'h1FF);
      for (int i = 0; i < 5; i++) begin
         for (int k = 1; k < 4; k++) send(k, int'($urandom_range(0, 511)));
      end
      for (int k = 1; k < 4; k++) drain(k);

      // 8N1 random traffic with random gaps; FIFO fills and stalls the source
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(0, int'($urandom_range(0, 255)));
      end
      drain(0);

      // Burst with valid held high from reset release
      rstn = 1'b0;
      wdata[0]  = 9'($urandom_range(0, 255));
      wvalid[0] = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      acc = 0;
      full_seen = 1'b0;
      for (int i = 0; i < 100 && !full_seen; i++) begin
         if (rdy_v[0]) begin
            push_exp(0, int'(wdata[0]) & mask(0));
            acc++;
            @(negedge clk);
            wdata[0] = 9'($urandom_range(0, 255));
         end else begin
            full_seen = 1'b1;
         end
      end
      wvalid[0] = 1'b0;
      check("burst_ready_dropped", full_seen, 1);
      check("burst_accepted", acc, DEPTH + 1);
      check("burst_level_full", level[0], DEPTH);
      ndone = 0;
      prev = -1;
      cyc = 0;
      gap_bad = 0;
      while (ndone < DEPTH + 1 && cyc < (DEPTH + 1) * 10 * CNT + 500) begin
         @(negedge clk);
         cyc++;
         if (done_v[0]) begin
            if (prev >= 0 && cyc - prev != 10 * CNT) gap_bad++;
            prev = cyc;
            ndone++;
         end
      end
      check("burst_done_count", ndone, DEPTH + 1);
      check("burst_done_spacing", gap_bad, 0);
      drain(0);

      // Reset in the data bits of the second of three queued frames
      for (int i = 0; i < 3; i++) begin
         w = int'($urandom_range(0, 255));
         send(0, w);
      end
      repeat (140) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("midrst_tx", tx_v[0], 1);
      check("midrst_level", level[0], 0);
      check("midrst_busy", busy_v[0], 0);
      check("midrst_ready", rdy_v[0], 1);
      check("midrst_done", done_v[0], 0);
      q0.delete();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      quiet = 0;
      repeat (300) begin
         @(negedge clk);
         if (!tx_v[0] || done_v[0] || busy_v[0]) quiet++;
      end
      check("midrst_no_more_frames", quiet, 0);

      for (int k = 0; k < 4; k++) check($sformatf("u%0d_final_level", k), level[k], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
